// File: rtl/line_buffer_ram.sv
// line_buffer_ram: rotating bank of N_TAPS-1 line RAMs emitting a vertical pixel column per input pixel
module line_buffer_ram #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 320,
  parameter int N_TAPS = 3,
  parameter int ADDR_W = 16
) (
  input  logic                     clock_i,
  input  logic                     reset_i,
  input  logic                     in_valid_i,
  input  logic                     in_sof_i,
  input  logic [DATA_W-1:0]        in_data_i,
  output logic                     out_valid_o,
  output logic [N_TAPS*DATA_W-1:0] out_col_o,
  output logic [ADDR_W-1:0]        out_x_o,
  output logic [15:0]              out_y_o,
  output logic                     out_full_o
);
  localparam int NB = N_TAPS - 1;
  localparam int AW = IMG_W > 1 ? $clog2(IMG_W) : 1;
  localparam int WW = NB > 1 ? $clog2(NB) : 1;
  localparam int FW = $clog2(N_TAPS);
  logic [ADDR_W-1:0] x_q, x_d, x_e;
  logic [15:0]       y_q, y_d, y_e;
  logic [WW-1:0]     wp_q, wp_d, wp_e, wp_o_q;
  logic [FW-1:0]     fill_q, fill_d, fill_e, fill_o_q;
  logic [DATA_W-1:0] pix_q;
  logic [DATA_W-1:0] rd [NB];
  logic              eol;
  // position of the incoming pixel (SOF forces the origin) and counters after it
  always_comb begin
    x_e    = in_sof_i ? '0 : x_q;
    y_e    = in_sof_i ? '0 : y_q;
    wp_e   = in_sof_i ? '0 : wp_q;
    fill_e = in_sof_i ? '0 : fill_q;
    eol    = x_e == ADDR_W'(IMG_W - 1);
    x_d    = eol ? '0 : x_e + 1'b1;
    y_d    = eol && y_e != 16'hFFFF ? y_e + 1'b1 : y_e;
    wp_d   = eol ? (wp_e == WW'(NB - 1) ? '0 : wp_e + 1'b1) : wp_e;
    fill_d = eol && fill_e != FW'(NB) ? fill_e + 1'b1 : fill_e;
  end
  // position counters advance only on valid pixels, so gaps stall them
  always_ff @(posedge clock_i or posedge reset_i)
    if (reset_i) begin
      x_q    <= '0;
      y_q    <= '0;
      wp_q   <= '0;
      fill_q <= '0;
    end else if (in_valid_i) begin
      x_q    <= x_d;
      y_q    <= y_d;
      wp_q   <= wp_d;
      fill_q <= fill_d;
    end
  // output stage aligned with the registered RAM reads; holds across gaps
  always_ff @(posedge clock_i or posedge reset_i)
    if (reset_i) begin
      out_valid_o <= 1'b0;
      pix_q       <= '0;
      out_x_o     <= '0;
      out_y_o     <= '0;
      out_full_o  <= 1'b0;
      wp_o_q      <= '0;
      fill_o_q    <= '0;
    end else begin
      out_valid_o <= in_valid_i;
      if (in_valid_i) begin
        pix_q      <= in_data_i;
        out_x_o    <= x_e;
        out_y_o    <= y_e;
        out_full_o <= y_e >= 16'(NB);
        wp_o_q     <= wp_e;
        fill_o_q   <= fill_e;
      end
    end
  for (genvar b = 0; b < NB; b++) begin : g_bank
    logic [DATA_W-1:0] mem [IMG_W];
    logic [DATA_W-1:0] rd_q;
    // read-before-write RAM: a same-address write returns the old line's pixel
    always_ff @(posedge clock_i)
      if (in_valid_i) begin
        rd_q <= mem[x_e[AW-1:0]];
        if (wp_e == WW'(b)) mem[x_e[AW-1:0]] <= in_data_i;
      end
    assign rd[b] = rd_q;
  end
  // slice k comes from the bank written k lines ago; rows not yet seen this frame read as 0
  always_comb begin
    out_col_o = '0;
    out_col_o[DATA_W-1:0] = pix_q;
    for (int k = 1; k < N_TAPS; k++)
      out_col_o[k*DATA_W +: DATA_W] = k > int'(fill_o_q) ? '0 : rd[(int'(wp_o_q) + NB - k) % NB];
  end
endmodule

// File: doc/line_buffer_ram.md
Name: line_buffer_ram

Overview:
- Parametrised successor to the single 8-bit line RAM used by the adaptive-thresholding path.
- Holds N_TAPS-1 previous image lines in a rotating bank of simple dual-port RAMs, each with a 1-cycle registered read.
- For every incoming pixel it emits a vertical column of N_TAPS pixels: the current pixel plus the same x in each stored line. This column feeds the local-window mean/threshold stage.
- Tracks x/y position and masks rows that have not yet been written in the current frame.

Parameters:
- DATA_W, 8: pixel width in bits.
- IMG_W, 320: pixels per line. Legal range 2..2^ADDR_W.
- N_TAPS, 3: column height. Stores N_TAPS-1 lines. Legal range 2..8.
- ADDR_W, 16: column address width; also the width of out_x.

Ports:
- clock  in  1  sole clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  pixel strobe; one pixel per asserted cycle; no backpressure.
- in_sof  in  1  start of frame; qualified by in_valid.
- in_data  in  DATA_W  pixel value.
- out_valid  out  1  in_valid delayed by one cycle.
- out_col  out  N_TAPS*DATA_W  bits [DATA_W-1:0] = current pixel (row y); slice k = row y-k.
- out_x  out  ADDR_W  column of the emitted pixel.
- out_y  out  16  row of the emitted pixel.
- out_full  out  1  all N_TAPS rows in out_col hold real data (y >= N_TAPS-1).

Behaviour:
- Reset (async, active-high) clears:
  - outputs: out_valid, out_col, out_x, out_y, out_full all 0;
  - internal: x, y, write-bank pointer wp, fill count.
  - RAM contents are not cleared; masking covers stale data.
- Latency: exactly 1 cycle from in_valid to out_valid, with out_col/out_x/out_y aligned to that pixel. With no in_valid, out_valid drops to 0 the next cycle and all other outputs hold.
- Per valid pixel at (x, y):
  - Read all N_TAPS-1 banks at address x.
  - Write in_data into bank wp at address x. Bank wp holds the oldest line.
  - Read-during-write to the same bank and address must return the OLD data.
  - Slice k (k >= 1) comes from bank (wp-k) mod (N_TAPS-1), delayed alongside the read.
- Masking: slice k is forced to 0 when k > fill. fill = number of completed lines in this frame, saturating at N_TAPS-1.
- Counters:
  - x increments on each valid pixel. At x = IMG_W-1 it wraps to 0.
  - On that wrap: y increments (saturating at 0xFFFF), wp advances mod (N_TAPS-1), fill increments (saturating).
  - out_full = (y >= N_TAPS-1) for the emitted pixel.
- in_sof with in_valid: that pixel is treated as (0,0).
  - x, y, wp and fill are taken as 0 for that pixel, so all upper slices are masked.
  - Counters then continue from it.
  - Takes priority over a line wrap in the same cycle.
- in_sof without in_valid is ignored.
- Gaps (in_valid low) stall all counters. The line buffer survives arbitrary gaps.
- Reset mid-line: the pipeline stage is dropped (out_valid 0). The next pixel is (0,0) with masked upper slices.
- No overflow or underflow conditions exist; the input rate is at most one pixel per clock.

Test Plan:
- Parameters for all scenarios: IMG_W=4, N_TAPS=3, DATA_W=8.
- Reset then frame fill: pulse reset; drive 12 consecutive pixels, data = index 0x00..0x0B, in_sof on the first.
  - Pixel 9 (x=1, y=2) -> out_col = {01,05,09} (top..bottom) one cycle later, out_x=1, out_y=2, out_full=1.
  - Pixel 5 -> out_col = {00,01,05}, out_full=0.
- Masking on first line: pixels 0..3 of the same frame -> slices 1 and 2 are 00 even if the RAM holds stale data from a prior frame, out_full=0.
- Gaps: same 12 pixels with in_valid low every other cycle -> identical out_col sequence; out_valid is high only on the cycle after each pixel.
- Mid-frame SOF: after 6 pixels, assert in_sof with data 0xAA -> out_x=0, out_y=0, out_col = {00,00,AA}. The following pixel has out_x=1.
- Reset mid-operation: assert reset asynchronously between clock edges during pixel 7 -> all outputs go to 0 immediately, with no out_valid for pixel 7. The next pixel reports (0,0) with masked slices.
- Read-during-write, long frame: 20 pixels, data = index. Pixel 16 (x=0, y=4) -> out_col = {08,0C,10}, confirming the wp rotation wraps correctly.
